// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared note codes, FSM encoding and half-period helper for tone_synth
package tone_pkg;

  // Note codes as presented by the keyboard/switch decoder
  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_C    = 3'd1;
  localparam logic [2:0] NOTE_D    = 3'd2;
  localparam logic [2:0] NOTE_E    = 3'd3;
  localparam logic [2:0] NOTE_F    = 3'd4;
  localparam logic [2:0] NOTE_G    = 3'd5;
  localparam logic [2:0] NOTE_A    = 3'd6;
  localparam logic [2:0] NOTE_B    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Octave-0 frequencies in Hz; entry 0 (rest) is never used for timing
  localparam int BASE_HZ [0:7] = '{0, 33, 37, 41, 44, 49, 55, 62};

  // Octave-0 half-period in clk cycles, floor division, never below 1
  function automatic int hp_base(input int clk_hz, input logic [2:0] note);
    int hp;
    if (note == NOTE_REST) return 1;
    hp = clk_hz / (2 * BASE_HZ[note]);
    if (hp < 1) hp = 1;
    return hp;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// rtl/tone_divider.sv - phase-continuous square-wave divider for one note/octave
//   clk      : system clock
//   rst      : synchronous active-high reset
//   run      : advance the half-period counter (PLAY / RELEASE)
//   load_now : start a fresh tone from note/octave (IDLE -> PLAY)
//   note     : current note code, 0 = rest
//   octave   : current octave select
//   square   : square-wave output
module tone_divider
  import tone_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int OCT_W  = 3,
  parameter int HP_W   = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load_now,
  input  logic [2:0]       note,
  input  logic [OCT_W-1:0] octave,
  output logic             square
);

  // Elaboration-time table; runtime octave scaling is a shift only
  localparam logic [HP_W-1:0] HP_TAB [0:7] = '{
    HP_W'(hp_base(CLK_HZ, NOTE_REST)),
    HP_W'(hp_base(CLK_HZ, NOTE_C)),
    HP_W'(hp_base(CLK_HZ, NOTE_D)),
    HP_W'(hp_base(CLK_HZ, NOTE_E)),
    HP_W'(hp_base(CLK_HZ, NOTE_F)),
    HP_W'(hp_base(CLK_HZ, NOTE_G)),
    HP_W'(hp_base(CLK_HZ, NOTE_A)),
    HP_W'(hp_base(CLK_HZ, NOTE_B))
  };

  logic [HP_W-1:0]  r_hp_cnt;
  logic [2:0]       r_note;
  logic [OCT_W-1:0] r_oct;
  logic             r_square;

  logic             w_take_new;
  logic [2:0]       w_note_sel;
  logic [OCT_W-1:0] w_oct_sel;
  logic [HP_W-1:0]  w_hp;
  logic [HP_W-1:0]  w_hp_m1;

  // New note/octave is adopted only at start or at a half-period boundary,
  // so a mid-period change never produces a runt half
  assign w_take_new = load_now | ((r_hp_cnt == '0) & (note != NOTE_REST));
  assign w_note_sel = w_take_new ? note : r_note;
  assign w_oct_sel  = w_take_new ? octave : r_oct;
  assign w_hp       = HP_TAB[w_note_sel] >> w_oct_sel;
  // Shifted-out high octaves clamp to HP=1 (toggle every cycle)
  assign w_hp_m1    = (w_hp == '0) ? '0 : w_hp - HP_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hp_cnt <= '0;
      r_note   <= NOTE_REST;
      r_oct    <= '0;
      r_square <= 1'b0;
    end else if (load_now) begin
      r_note   <= note;
      r_oct    <= octave;
      r_square <= 1'b1;
      r_hp_cnt <= w_hp_m1;
    end else if (run) begin
      if (r_hp_cnt == '0) begin
        r_square <= ~r_square;
        r_hp_cnt <= w_hp_m1;
        if (w_take_new) begin
          r_note <= note;
          r_oct  <= octave;
        end
      end else begin
        r_hp_cnt <= r_hp_cnt - HP_W'(1);
      end
    end else begin
      r_square <= 1'b0;
      r_hp_cnt <= '0;
    end
  end

  assign square = r_square;

endmodule

// File: rtl/tone_synth.sv
// rtl/tone_synth.sv - square-wave tone synthesiser with PWM volume and release envelope
//   clk     : system clock
//   rst     : synchronous active-high reset
//   note    : 0 = key up, 1..7 = C..B
//   octave  : octave select, 0 = lowest
//   volume  : held-key level, 0 = silent
//   AIN     : registered PWM-gated square wave
//   GAIN    : constant GAIN_SEL
//   NC      : constant 0
//   ACTIVE  : registered, high whenever not idle
//   playing : registered, high while a key is held
module tone_synth
  import tone_pkg::*;
#(
  parameter int   CLK_HZ    = 100000000,
  parameter int   OCT_W     = 3,
  parameter int   VOL_W     = 4,
  parameter int   DECAY_CYC = 1562500,
  parameter logic GAIN_SEL  = 1'b1,
  parameter int   HP_W      = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       note,
  input  logic [OCT_W-1:0] octave,
  input  logic [VOL_W-1:0] volume,
  output logic             AIN,
  output logic             GAIN,
  output logic             NC,
  output logic             ACTIVE,
  output logic             playing
);

  localparam int              DC_W      = (DECAY_CYC > 1) ? $clog2(DECAY_CYC) : 1;
  localparam logic [DC_W-1:0] DECAY_RLD = DC_W'(DECAY_CYC - 1);

  state_t           r_state;
  logic [VOL_W-1:0] r_level;
  logic [VOL_W-1:0] r_pwm_cnt;
  logic [DC_W-1:0]  r_decay_cnt;
  logic             r_ain;
  logic             r_active;
  logic             r_playing;

  logic             w_square;
  logic             w_key_down;
  logic             w_load_now;
  logic             w_run;

  assign w_key_down = (note != NOTE_REST);
  assign w_load_now = (r_state == ST_IDLE) & w_key_down;
  // The divider keeps running through release until the envelope empties;
  // a re-press at level 0 wins over the return to idle
  assign w_run = (r_state == ST_PLAY) |
                 ((r_state == ST_RELEASE) & (w_key_down | (r_level != '0)));

  tone_divider #(
    .CLK_HZ (CLK_HZ),
    .OCT_W  (OCT_W),
    .HP_W   (HP_W)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .run      (w_run),
    .load_now (w_load_now),
    .note     (note),
    .octave   (octave),
    .square   (w_square)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_level     <= '0;
      r_decay_cnt <= '0;
      r_active    <= 1'b0;
      r_playing   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_key_down) begin
            r_state   <= ST_PLAY;
            r_level   <= volume;
            r_active  <= 1'b1;
            r_playing <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (w_key_down) begin
            r_level <= volume;
          end else begin
            // Level holds its last held-key value as the start of the decay
            r_state     <= ST_RELEASE;
            r_decay_cnt <= DECAY_RLD;
            r_playing   <= 1'b0;
          end
        end
        ST_RELEASE: begin
          if (w_key_down) begin
            r_state   <= ST_PLAY;
            r_level   <= volume;
            r_playing <= 1'b1;
          end else if (r_level == '0) begin
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
          end else if (r_decay_cnt == '0) begin
            r_level     <= r_level - VOL_W'(1);
            r_decay_cnt <= DECAY_RLD;
          end else begin
            r_decay_cnt <= r_decay_cnt - DC_W'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_active  <= 1'b0;
          r_playing <= 1'b0;
        end
      endcase
    end
  end

  // Free-running PWM compare; level 2^VOL_W-1 leaves one low slot per frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_ain     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + VOL_W'(1);
      r_ain     <= w_square & (r_pwm_cnt < r_level);
    end
  end

  assign AIN     = r_ain;
  assign GAIN    = GAIN_SEL;
  assign NC      = 1'b0;
  assign ACTIVE  = r_active;
  assign playing = r_playing;

endmodule

// File: tb/tb_tone_synth.sv
// tb/tb_tone_synth.sv - randomized self-checking bench for tone_synth against an event-time model
module tb_tone_synth;

  localparam int CLK_HZ    = 6600;
  localparam int OCT_W     = 3;
  localparam int VOL_W     = 4;
  localparam int DECAY_CYC = 10;
  localparam int HP_W      = 12;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_REL  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       note = 3'd0;
  logic [OCT_W-1:0] octave = '0;
  logic [VOL_W-1:0] volume = '0;
  logic             AIN, GAIN, NC, ACTIVE, playing;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tone_synth #(
    .CLK_HZ    (CLK_HZ),
    .OCT_W     (OCT_W),
    .VOL_W     (VOL_W),
    .DECAY_CYC (DECAY_CYC),
    .GAIN_SEL  (1'b1),
    .HP_W      (HP_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .note    (note),
    .octave  (octave),
    .volume  (volume),
    .AIN     (AIN),
    .GAIN    (GAIN),
    .NC      (NC),
    .ACTIVE  (ACTIVE),
    .playing (playing)
  );

  int base_hz [8] = '{0, 33, 37, 41, 44, 49, 55, 62};

  // Model: square edges are absolute edge numbers, release level is closed form
  int cyc = 0;
  int m_st = M_IDLE;
  int m_lvl = 0, m_pwm = 0, m_nxt = 0, m_note = 0, m_oct = 0, m_t0 = 0, m_l0 = 0;
  bit m_sq = 0, m_ain = 0;

  function automatic int hp_of(input int n, input int k);
    int h;
    if (n == 0) return 1;
    h = (CLK_HZ / (2 * base_hz[n])) >> k;
    return (h < 1) ? 1 : h;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_boundary();
    if (cyc == m_nxt) begin
      m_sq = ~m_sq;
      if (note != 0) begin
        m_note = int'(note);
        m_oct  = int'(octave);
      end
      m_nxt = cyc + hp_of(m_note, m_oct);
    end
  endtask

  task automatic model_edge();
    cyc++;
    if (rst) begin
      m_st = M_IDLE; m_lvl = 0; m_pwm = 0; m_sq = 0; m_ain = 0;
      m_note = 0; m_oct = 0; m_nxt = 0;
      return;
    end
    m_ain = m_sq && (m_pwm < m_lvl);
    m_pwm = (m_pwm + 1) % (1 << VOL_W);
    case (m_st)
      M_IDLE: begin
        if (note != 0) begin
          m_st = M_PLAY;
          m_note = int'(note);
          m_oct = int'(octave);
          m_sq = 1;
          m_nxt = cyc + hp_of(m_note, m_oct);
          m_lvl = int'(volume);
        end else begin
          m_sq = 0;
        end
      end
      M_PLAY: begin
        model_boundary();
        if (note == 0) begin
          m_st = M_REL;
          m_t0 = cyc;
          m_l0 = m_lvl;
        end else begin
          m_lvl = int'(volume);
        end
      end
      default: begin
        if (note != 0) begin
          model_boundary();
          m_st = M_PLAY;
          m_lvl = int'(volume);
        end else if (m_lvl == 0) begin
          m_st = M_IDLE;
          m_sq = 0;
        end else begin
          model_boundary();
          m_lvl = m_l0 - (cyc - m_t0) / DECAY_CYC;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("AIN", int'(AIN), int'(m_ain));
    check("ACTIVE", int'(ACTIVE), (m_st != M_IDLE) ? 1 : 0);
    check("playing", int'(playing), (m_st == M_PLAY) ? 1 : 0);
    check("GAIN", int'(GAIN), 1);
    check("NC", int'(NC), 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step();
  endtask

  initial begin
    int n;
    int ain_highs;

    // Reset state
    rst = 1'b1;
    run_cycles(2);

    // Basic tone, full volume
    rst = 1'b0; note = 3'd1; octave = '0; volume = 4'd15;
    run_cycles(450);

    // Switch note about 40 cycles into a high half
    for (int i = 0; i < 400 && !(m_sq && (m_nxt - cyc) == 60); i++) step();
    note = 3'd2;
    run_cycles(400);

    // Octave scaling and HP clamp at top octave
    note = 3'd1; octave = 3'd1;
    run_cycles(300);
    note = 3'd7; octave = 3'd7;
    run_cycles(60);

    // Release length from level 4
    note = 3'd1; octave = '0; volume = 4'd4;
    run_cycles(30);
    note = 3'd0;
    n = 0;
    do begin
      step();
      n++;
    end while (ACTIVE && n < 100);
    check("release_len", n - 1, 41);

    // Re-press during release at level 2
    note = 3'd1; volume = 4'd4;
    run_cycles(30);
    note = 3'd0;
    run_cycles(21);
    check("release_level", m_lvl, 2);
    note = 3'd1; volume = 4'd9;
    run_cycles(300);

    // Reset mid-note, then silent volume while playing
    rst = 1'b1;
    step();
    check("rst_ain", int'(AIN), 0);
    check("rst_active", int'(ACTIVE), 0);
    rst = 1'b0; note = 3'd3; volume = 4'd0;
    ain_highs = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (AIN) ain_highs++;
    end
    check("vol0_ain_highs", ain_highs, 0);
    check("vol0_playing", int'(playing), 1);

    // Randomized segments
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 2) == 0) note = 3'd0;
      else note = 3'($urandom_range(1, 7));
      octave = OCT_W'($urandom_range(0, 7));
      volume = VOL_W'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        run_cycles(int'($urandom_range(1, 2)));
        rst = 1'b0;
      end
      run_cycles(int'($urandom_range(1, 120)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tone_synth.md
Name: tone_synth

Overview:
Parametrised successor to the board's single-voice piano amplifier driver. Generates a square-wave tone for a 7-note diatonic scale over 2^OCT_W octaves. Adds volume control by PWM gating, a release envelope with a small state machine, and phase-continuous note switching. Drives the 4-pin mono amplifier header (AIN, GAIN, NC, ACTIVE) directly from the keyboard/switch decoder outputs.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz; sets all period constants
OCT_W, 3, octave select width; octave k divides base half-period by 2^k
VOL_W, 4, volume/envelope level width; also the PWM counter width
DECAY_CYC, 1562500, clk cycles per envelope level step during release (>=1)
GAIN_SEL, 1, constant driven on GAIN (1 = lower dB)
HP_W, 22, half-period counter width; must hold CLK_HZ/66 - 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
note  in  3  0 = rest/key up; 1..7 = C,D,E,F,G,A,B
octave  in  OCT_W  octave select, 0 = lowest
volume  in  VOL_W  target level while key held; 0 = silent
AIN  out  1  registered PWM-gated square wave to amplifier
GAIN  out  1  constant GAIN_SEL
NC  out  1  constant 0
ACTIVE  out  1  registered; 1 when state != IDLE (amp enabled)
playing  out  1  registered; 1 when state == PLAY

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state is updated on posedge clk.
- Reset values: state=IDLE, AIN=0, ACTIVE=0, playing=0, square=0, hp_cnt=0, level=0, pwm_cnt=0, decay_cnt=0, latched note/octave=0. GAIN=GAIN_SEL and NC=0 at all times, including during reset.
- Base frequencies (Hz, octave 0): C 33, D 37, E 41, F 44, G 49, A 55, B 62.
- Half-period HP(n,k) = max(1, (CLK_HZ / (2*BASE[n])) >> k). Use integer floor division, computed at elaboration as a constant table. Runtime logic is shift only.
- States: IDLE, PLAY, RELEASE.
- IDLE -> PLAY when note != 0. On that edge:
  - latch note/octave;
  - square <= 1;
  - hp_cnt <= HP-1;
  - level <= volume.
- PLAY:
  - hp_cnt decrements each cycle.
  - At hp_cnt==0: toggle square and reload hp_cnt with HP-1 computed from the *current* inputs if note != 0. The new note/octave is latched at that same edge, which keeps the phase continuous.
  - Mid-period changes to note/octave take effect only at the next boundary.
  - level <= volume every cycle.
- PLAY -> RELEASE when note == 0. The tone continues at the last latched note/octave.
- RELEASE:
  - decay_cnt counts DECAY_CYC-1 down to 0; at 0, level decrements by 1 and decay_cnt reloads.
  - When level==0 (including on entry): go to IDLE next edge, with square <= 0 and hp_cnt <= 0.
- RELEASE -> PLAY when note != 0. level <= volume; the tone keeps its phase and the new note is latched at the next boundary.
- Simultaneous events: a key-up check and an hp boundary in the same cycle both apply. Key-up takes priority over a decay step.
- PWM and AIN:
  - pwm_cnt is free-running with VOL_W bits and wraps at 2^VOL_W-1 -> 0.
  - AIN <= square & (pwm_cnt < level). Latency is 1 cycle from square/level.
  - level = 2^VOL_W-1 gives duty (2^VOL_W-1)/2^VOL_W on high half-periods.
  - volume = 0 in PLAY gives AIN = 0 while the block stays in PLAY.
- rst asserted mid-note: all state returns to reset values on that edge, with no release tail.
- Octave at maximum with HP clamped to 1: square toggles every cycle. This is legal.

Decomposition:
- Package tone_pkg:
  - note code constants (NOTE_REST=0, NOTE_C=1 .. NOTE_B=7);
  - state enum encoding;
  - BASE_HZ constant array;
  - function hp_base(clk_hz, note) returning the octave-0 half-period.
- Sub-module tone_divider: hp_cnt, square, latched note/octave, boundary reload logic. Inputs: clk, rst, run, load_now, note, octave. Output: square.
- tone_synth holds the FSM, envelope, PWM and output registers.

Test Plan:
1. CLK_HZ=6600, VOL_W=4, volume=15. rst 2 cycles, then note=1, octave=0 -> ACTIVE/playing high 1 cycle after; square high 100 cycles, low 100; AIN high 15 of every 16 cycles in high halves.
2. Mid-period switch: note 1 -> 2 at cycle 40 of a high half -> current half still lasts 100 cycles; next halves are 89 cycles (6600/74); no runt pulse.
3. octave=1, note=1 -> 50-cycle halves. octave=7, note=7 (HP=53>>7 -> 1) -> square toggles every cycle.
4. DECAY_CYC=10, volume=4: note -> 0 -> playing=0 next cycle; level steps 4,3,2,1,0 every 10 cycles; IDLE, ACTIVE=0 and AIN=0 about 41 cycles after key-up.
5. Re-press during RELEASE at level=2 with volume=9 -> back to PLAY; level=9 next cycle; square phase unbroken.
6. rst asserted mid-PLAY -> next edge AIN=0, ACTIVE=0, playing=0; GAIN=1 and NC=0 throughout. volume=0 in PLAY -> AIN stays 0 while playing=1.
